// File: rtl/acondicionador_botones.sv
// Button conditioner for the tic-tac-toe VGA controller: synchronizes, debounces and
// turns each press into a one-cycle pulse; the search button also auto-repeats.
module acondicionador_botones #(
  parameter int CICLOS_REBOTE          = 250000,
  parameter int CICLOS_REPETIR_INICIAL = 12500000,
  parameter int CICLOS_REPETIR         = 5000000,
  parameter int BOTON_ACTIVO_BAJO      = 1
) (
  input  logic clk25,
  input  logic botonRST,
  input  logic botonBuscarIn,
  input  logic botonSeleccionarIn,
  output logic buscarPulso,
  output logic seleccionarPulso,
  output logic buscarEstable,
  output logic seleccionarEstable
);
  localparam int RW   = $clog2(CICLOS_REBOTE);
  localparam int MAXR = (CICLOS_REPETIR_INICIAL > CICLOS_REPETIR) ? CICLOS_REPETIR_INICIAL
                                                                   : CICLOS_REPETIR;
  localparam int PW   = $clog2(MAXR);
  localparam logic          LIBRE     = (BOTON_ACTIVO_BAJO != 0);
  localparam logic [RW-1:0] REB_FIN   = RW'(CICLOS_REBOTE - 1);
  localparam logic [PW-1:0] REP_INI   = PW'(CICLOS_REPETIR_INICIAL - 1);
  localparam logic [PW-1:0] REP_FIN   = PW'(CICLOS_REPETIR - 1);

  typedef enum logic [1:0] {REPOSO, PRIMERA_ESPERA, REPITIENDO} estado_t;

  // Channel 0 = search, channel 1 = select.
  logic [1:0]         crudo;
  logic [1:0]         sync1_q, sync2_q, sinc_q, estable_q;
  logic [1:0][RW-1:0] reb_q;
  logic [1:0]         acepta, sube;
  logic               repetir;
  estado_t            estado_q;
  logic [PW-1:0]      rep_q;
  logic               buscar_pulso_q, selec_pulso_q;

  assign crudo = {botonSeleccionarIn, botonBuscarIn};

  always_comb begin
    acepta = '0;
    sube   = '0;
    for (int i = 0; i < 2; i++) begin
      acepta[i] = (sinc_q[i] != estable_q[i]) && (reb_q[i] == REB_FIN);
      sube[i]   = acepta[i] && sinc_q[i];
    end
  end

  // The inverted level is registered so every output is a flop and the
  // new level must persist for CICLOS_REBOTE consecutive sinc_q samples.
  always_ff @(posedge clk25 or negedge botonRST) begin
    if (!botonRST) begin
      sync1_q   <= {2{LIBRE}};
      sync2_q   <= {2{LIBRE}};
      sinc_q    <= '0;
      estable_q <= '0;
      reb_q     <= '0;
    end else begin
      sync1_q <= crudo;
      sync2_q <= sync1_q;
      sinc_q  <= sync2_q ^ {2{LIBRE}};
      for (int i = 0; i < 2; i++) begin
        if (sinc_q[i] == estable_q[i]) begin
          reb_q[i] <= '0;
        end else if (acepta[i]) begin
          estable_q[i] <= sinc_q[i];
          reb_q[i]     <= '0;
        end else begin
          reb_q[i] <= reb_q[i] + 1'b1;
        end
      end
    end
  end

  assign repetir = estable_q[0] &&
                   (((estado_q == PRIMERA_ESPERA) && (rep_q == REP_INI)) ||
                    ((estado_q == REPITIENDO)     && (rep_q == REP_FIN)));

  // Select wins a collision; the repeat counter runs on regardless.
  always_ff @(posedge clk25 or negedge botonRST) begin
    if (!botonRST) begin
      estado_q       <= REPOSO;
      rep_q          <= '0;
      buscar_pulso_q <= 1'b0;
      selec_pulso_q  <= 1'b0;
    end else begin
      buscar_pulso_q <= (sube[0] | repetir) & ~sube[1];
      selec_pulso_q  <= sube[1];
      case (estado_q)
        REPOSO: begin
          if (sube[0]) begin
            estado_q <= PRIMERA_ESPERA;
            rep_q    <= '0;
          end
        end
        PRIMERA_ESPERA: begin
          if (!estable_q[0]) begin
            estado_q <= REPOSO;
            rep_q    <= '0;
          end else if (rep_q == REP_INI) begin
            estado_q <= REPITIENDO;
            rep_q    <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
        REPITIENDO: begin
          if (!estable_q[0]) begin
            estado_q <= REPOSO;
            rep_q    <= '0;
          end else if (rep_q == REP_FIN) begin
            rep_q <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
        default: begin
          estado_q <= REPOSO;
          rep_q    <= '0;
        end
      endcase
    end
  end

  assign buscarPulso        = buscar_pulso_q;
  assign seleccionarPulso   = selec_pulso_q;
  assign buscarEstable      = estable_q[0];
  assign seleccionarEstable = estable_q[1];
endmodule
